// File: rtl/mcseq_pkg.sv
// mcseq_pkg
// Purpose: constants shared by the microcode sequencer and the microcode
//          assembler. Holds the sequencing-field encodings, the word field
//          widths, the condition-flag indices, the FSM state type and the
//          default configuration (word size, ROM depth, slot size, reset slot).
// Ports:   none (package only).
package mcseq_pkg;

  // Default configuration. RESET_OPCODE selects the slot run after reset.
  // 0x02 is an unused 6502 opcode (KIL), so it cannot collide with real code.
  localparam int          DEFAULT_WORD_SIZE    = 16;
  localparam int          DEFAULT_ROM_SIZE     = 1024;
  localparam int          DEFAULT_SLOT_BITS    = 2;
  localparam logic [7:0]  DEFAULT_RESET_OPCODE = 8'h02;
  localparam logic [7:0]  IRQ_OPCODE           = 8'h00;

  // Word layout from the MSB down: SEQ (2 bits), COND (2 bits), then CTRL
  // fills the remaining low bits. For 16-bit words this is SEQ=[15:14],
  // COND=[13:12], CTRL=[11:0].
  localparam int SEQ_W  = 2;
  localparam int COND_W = 2;
  localparam int FLAG_W = 4;

  // Sequencing field encodings.
  typedef enum logic [SEQ_W-1:0] {
    SEQ_NEXT = 2'b00,
    SEQ_END  = 2'b01,
    SEQ_SKIP = 2'b10,
    SEQ_HOLD = 2'b11
  } seq_e;

  // COND indexes the flags bus {V,N,Z,C}.
  localparam logic [COND_W-1:0] COND_C = 2'd0;
  localparam logic [COND_W-1:0] COND_Z = 2'd1;
  localparam logic [COND_W-1:0] COND_N = 2'd2;
  localparam logic [COND_W-1:0] COND_V = 2'd3;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

endpackage

// File: rtl/microcode_sequencer.sv
// microcode_sequencer
// Purpose: steps through the registered microcode ROM (1-cycle read
//          latency) for the 6502 core. Each opcode owns a slot of
//          2**SLOT_BITS words starting at {opcode, 0}. The SEQ field of each
//          returned word chooses the next address. The CTRL field goes to
//          the datapath together with a valid strobe.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   op_valid   in   opcode available from the fetch path
//   op_data    in   [7:0] opcode byte
//   op_ready   out  sequencer can accept an opcode this cycle
//   rom_addr   out  [ADDR_W-1:0] ROM address, sampled by the ROM at the next edge
//   rom_word   in   [WORD_SIZE-1:0] registered ROM output
//   flags      in   [3:0] condition inputs {V,N,Z,C}, indexed by COND
//   stall      in   datapath/memory not ready; the sequencer freezes
//   ctrl_out   out  [WORD_SIZE-5:0] control field, zero unless ctrl_valid
//   ctrl_valid out  ctrl_out must be applied this cycle
//   instr_done out  pulse on the last micro-op of an instruction
//   ucode_err  out  pulse when a micro-op would run past the end of its slot
//   irq_req    in   (MCSEQ_IRQ_EN only) level interrupt request
//   irq_ack    out  (MCSEQ_IRQ_EN only) pulse when the BRK slot is dispatched
// Optional feature: define MCSEQ_IRQ_EN to add interrupt dispatch from FETCH.
module microcode_sequencer
  import mcseq_pkg::*;
#(
  parameter int         WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int         ROM_SIZE     = DEFAULT_ROM_SIZE,
  parameter int         SLOT_BITS    = DEFAULT_SLOT_BITS,
  parameter logic [7:0] RESET_OPCODE = DEFAULT_RESET_OPCODE,
  localparam int        ADDR_W       = $clog2(ROM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [7:0]            op_data,
  output logic                  op_ready,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [WORD_SIZE-1:0]  rom_word,
  input  logic [FLAG_W-1:0]     flags,
  input  logic                  stall,
  output logic [WORD_SIZE-5:0]  ctrl_out,
  output logic                  ctrl_valid,
  output logic                  instr_done,
`ifdef MCSEQ_IRQ_EN
  input  logic                  irq_req,
  output logic                  irq_ack,
`endif
  output logic                  ucode_err
);

  localparam int SEQ_LSB  = WORD_SIZE - SEQ_W;
  localparam int COND_LSB = SEQ_LSB - COND_W;
  localparam int CTRL_W   = WORD_SIZE - SEQ_W - COND_W;

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'({RESET_OPCODE, {SLOT_BITS{1'b0}}});

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]     op_addr;

  seq_e                  seq;
  logic [COND_W-1:0]     cond;
  logic                  cond_true;
  logic [SLOT_BITS:0]    step;
  logic [SLOT_BITS:0]    ofs_sum;
  logic                  overrun;
  logic [ADDR_W-1:0]     adv_addr;

  assign op_addr = ADDR_W'({op_data, {SLOT_BITS{1'b0}}});

  // The advance is computed inside the slot offset with one extra carry bit.
  // A carry means the step would leave the slot. In that case the upper
  // address bits are never incremented, so the neighbouring slot is never
  // addressed.
  always_comb begin
    seq       = seq_e'(rom_word[SEQ_LSB +: SEQ_W]);
    cond      = rom_word[COND_LSB +: COND_W];
    cond_true = flags[cond];
    step      = (seq == SEQ_SKIP && cond_true) ? (SLOT_BITS+1)'(2) : (SLOT_BITS+1)'(1);
    ofs_sum   = {1'b0, cur_addr_q[SLOT_BITS-1:0]} + step;
    overrun   = ofs_sum[SLOT_BITS];
    adv_addr  = {cur_addr_q[ADDR_W-1:SLOT_BITS], ofs_sum[SLOT_BITS-1:0]};
  end

  // Next-state and output logic. Whenever the sequencer does not advance,
  // rom_addr re-presents cur_addr. This keeps the registered rom_word in
  // step with cur_addr, so a frozen or held word is still correct when
  // execution resumes.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rom_addr   = cur_addr_q;
    op_ready   = 1'b0;
    ctrl_valid = 1'b0;
    ctrl_out   = '0;
    instr_done = 1'b0;
    ucode_err  = 1'b0;
`ifdef MCSEQ_IRQ_EN
    irq_ack    = 1'b0;
`endif

    if (rst) begin
      state_d    = ST_RESET;
      cur_addr_d = RESET_ADDR;
      rom_addr   = RESET_ADDR;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          rom_addr   = RESET_ADDR;
          cur_addr_d = RESET_ADDR;
          state_d    = ST_EXEC;
        end

        ST_FETCH: begin
`ifdef MCSEQ_IRQ_EN
          // A pending interrupt takes the dispatch slot ahead of any opcode.
          op_ready = !stall && !irq_req;
          if (irq_req && !stall) begin
            irq_ack    = 1'b1;
            rom_addr   = ADDR_W'({IRQ_OPCODE, {SLOT_BITS{1'b0}}});
            cur_addr_d = ADDR_W'({IRQ_OPCODE, {SLOT_BITS{1'b0}}});
            state_d    = ST_EXEC;
          end else if (op_valid && op_ready) begin
`else
          op_ready = !stall;
          if (op_valid && op_ready) begin
`endif
            rom_addr   = op_addr;
            cur_addr_d = op_addr;
            state_d    = ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (!stall) begin
            ctrl_valid = 1'b1;
            ctrl_out   = rom_word[CTRL_W-1:0];
            if (seq == SEQ_END) begin
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end else if (seq == SEQ_HOLD && !cond_true) begin
              // The word repeats. The defaults keep rom_addr on cur_addr.
            end else if (overrun) begin
              ucode_err  = 1'b1;
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end else begin
              rom_addr   = adv_addr;
              cur_addr_d = adv_addr;
            end
          end
        end

        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  // State and current-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      cur_addr_q <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
    end
  end

endmodule
